// File: rtl/seq_check_pkg.sv
// Shared types and constants for the sequence checker.
//   seq_sel_e   : sequence selector (value of the 3-bit sel input)
//   state_e     : checker FSM states
//   term_hist_t : current term plus two history terms
//   init_terms  : first term and seed history for each sequence
package seq_check_pkg;

  typedef enum logic [2:0] {
    SQR  = 3'd0,
    EXP3 = 3'd1,
    TRI  = 3'd2,
    FIB  = 3'd3,
    PELL = 3'd4,
    LUC  = 3'd5,
    PAD  = 3'd6,
    SYLV = 3'd7
  } seq_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2,
    FAIL   = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] cur;
    logic [7:0] h1;
    logic [7:0] h2;
  } term_hist_t;

  // History seeds are the terms "before" the first one, so that the
  // recurrence yields the second term directly (mod 256).
  localparam term_hist_t INIT_SQR  = '{cur: 8'd1, h1: 8'd0,   h2: 8'd0};
  localparam term_hist_t INIT_EXP3 = '{cur: 8'd1, h1: 8'd0,   h2: 8'd0};
  localparam term_hist_t INIT_TRI  = '{cur: 8'd1, h1: 8'd0,   h2: 8'd0};
  localparam term_hist_t INIT_FIB  = '{cur: 8'd1, h1: 8'd0,   h2: 8'd0};
  localparam term_hist_t INIT_PELL = '{cur: 8'd0, h1: 8'd1,   h2: 8'd0};
  localparam term_hist_t INIT_LUC  = '{cur: 8'd2, h1: 8'd255, h2: 8'd0};
  localparam term_hist_t INIT_PAD  = '{cur: 8'd1, h1: 8'd0,   h2: 8'd1};
  localparam term_hist_t INIT_SYLV = '{cur: 8'd2, h1: 8'd0,   h2: 8'd0};

  function automatic term_hist_t init_terms(input seq_sel_e s);
    term_hist_t t;
    case (s)
      SQR:     t = INIT_SQR;
      EXP3:    t = INIT_EXP3;
      TRI:     t = INIT_TRI;
      FIB:     t = INIT_FIB;
      PELL:    t = INIT_PELL;
      LUC:     t = INIT_LUC;
      PAD:     t = INIT_PAD;
      SYLV:    t = INIT_SYLV;
      default: t = INIT_SQR;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/seq_check_term_gen.sv
// Term generator: holds the selected sequence, a term index and three
// history registers, and presents the current expected term.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : load first term of sel_i
//   adv_i      : advance to the next term
//   sel_i      : sequence select (used only with load_i)
//   term_o     : current expected term
module seq_term_gen
  import seq_check_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       adv_i,
  input  seq_sel_e   sel_i,
  output logic [7:0] term_o
);

  seq_sel_e   sel_q;
  logic [7:0] cur_q, h1_q, h2_q, idx_q;
  logic [7:0] nxt_d;
  logic [7:0] sq;
  term_hist_t init;

  assign init = init_terms(sel_i);
  assign sq   = cur_q * cur_q;

  // idx_q holds k of the current term for SQR/TRI; all arithmetic wraps.
  always_comb begin
    nxt_d = cur_q;
    case (sel_q)
      SQR:     nxt_d = cur_q + {idx_q[6:0], 1'b0} + 8'd1;
      EXP3:    nxt_d = cur_q + {cur_q[6:0], 1'b0};
      TRI:     nxt_d = cur_q + idx_q + 8'd1;
      FIB:     nxt_d = cur_q + h1_q;
      PELL:    nxt_d = {cur_q[6:0], 1'b0} + h1_q;
      LUC:     nxt_d = cur_q + h1_q;
      PAD:     nxt_d = h1_q + h2_q;
      SYLV:    nxt_d = sq - cur_q + 8'd1;
      default: nxt_d = cur_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= SQR;
      cur_q <= '0;
      h1_q  <= '0;
      h2_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      sel_q <= sel_i;
      cur_q <= init.cur;
      h1_q  <= init.h1;
      h2_q  <= init.h2;
      idx_q <= 8'd1;
    end else if (adv_i) begin
      cur_q <= nxt_d;
      h1_q  <= cur_q;
      h2_q  <= h1_q;
      idx_q <= idx_q + 8'd1;
    end
  end

  assign term_o = cur_q;

endmodule

// File: rtl/seq_check.sv
// Sequence checker: compares incoming samples against a selected integer
// sequence (mod 256) and reports match/mismatch with one cycle latency.
//   clk, rst_n       : clock, synchronous active-low reset
//   start, sel       : load sequence sel and begin checking
//   in_valid,in_data : received sample
//   match, mismatch  : one-cycle result pulses
//   locked, failed   : state LOCKED / FAIL
//   term_count       : matched terms since start (saturating)
//   expected         : next expected term
//   err_count        : mismatch count, only when SEQ_CHECK_ERRCNT_EN is
//                      defined; otherwise constant 0
module seq_check
  import seq_check_pkg::*;
#(
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] sel,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       match,
  output logic       mismatch,
  output logic       locked,
  output logic       failed,
  output logic [7:0] term_count,
  output logic [7:0] expected,
  output logic [7:0] err_count
);

  localparam logic [7:0] LOCK_LEN_B = 8'(LOCK_LEN);

  state_e     state_q, state_d;
  logic       match_q, match_d, mismatch_q, mismatch_d;
  logic [7:0] tc_q, tc_d, run_q, run_d, run_inc;
  logic       load, adv;
  logic [7:0] term;

  seq_term_gen u_term_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .adv_i  (adv),
    .sel_i  (seq_sel_e'(sel)),
    .term_o (term)
  );

  // Consecutive-match counter stops at LOCK_LEN so it never wraps.
  assign run_inc = (run_q >= LOCK_LEN_B) ? run_q : run_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    tc_d       = tc_q;
    run_d      = run_q;
    load       = 1'b0;
    adv        = 1'b0;
    if (start) begin
      state_d = CHECK;
      load    = 1'b1;
      tc_d    = '0;
      run_d   = '0;
    end else begin
      case (state_q)
        CHECK, LOCKED: begin
          if (in_valid) begin
            if (in_data == term) begin
              match_d = 1'b1;
              adv     = 1'b1;
              tc_d    = (tc_q == 8'hFF) ? tc_q : tc_q + 8'd1;
              run_d   = run_inc;
              if (run_inc >= LOCK_LEN_B) state_d = LOCKED;
            end else begin
              mismatch_d = 1'b1;
              state_d    = FAIL;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
      tc_q       <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      tc_q       <= tc_d;
      run_q      <= run_d;
    end
  end

`ifdef SEQ_CHECK_ERRCNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                          err_q <= '0;
    else if (mismatch_d && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign match      = match_q;
  assign mismatch   = mismatch_q;
  assign locked     = (state_q == LOCKED);
  assign failed     = (state_q == FAIL);
  assign term_count = tc_q;
  assign expected   = term;

endmodule
